wb_merge_unit: RTL and testbench
================================

Name: wb_merge_unit

Overview:
- Sits directly downstream of the execute stage.
- Merges two result streams onto a single scoreboard writeback port:
  - Port A: fixed-latency FLU results; never back-pressured, always wins arbitration.
  - Port B: variable-latency vector-unit results; valid/ready handshake, buffered in a small FIFO.
- A starvation counter raises a stall request to issue so buffered B results eventually drain.

Parameters:
- DEPTH, 4: B-side FIFO entries; power of two, at least 2.
- MAX_STALL, 8: consecutive cycles a non-empty FIFO may be starved by A before stall_a_o asserts; at least 1.
- XLEN, riscv::XLEN: result width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  pipeline flush
- a_valid_i  in  1  A result valid
- a_trans_id_i  in  TRANS_ID_BITS  A scoreboard id
- a_result_i  in  XLEN  A result
- a_ex_valid_i  in  1  A carries an exception
- b_valid_i  in  1  B result valid
- b_ready_o  out  1  FIFO can accept B
- b_trans_id_i  in  TRANS_ID_BITS  B scoreboard id
- b_result_i  in  XLEN  B result
- wb_valid_o  out  1  writeback valid
- wb_trans_id_o  out  TRANS_ID_BITS  writeback id
- wb_result_o  out  XLEN  writeback data
- wb_ex_valid_o  out  1  writeback exception flag
- stall_a_o  out  1  request to issue to withhold A-side instructions
- fifo_count_o  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high): FIFO pointers = 0, count = 0, starvation counter = 0, stall_a_o = 0. Consequently b_ready_o = 1 and wb_valid_o = 0 while inputs are idle.
- Interface: one clock (clk_i), reset rst_i asynchronous active-high.
- B push: occurs when b_valid_i && b_ready_o && !flush_i.
  - b_ready_o = (count < DEPTH), driven from registered count only.
  - No same-cycle pop-to-ready bypass: when full, b_ready_o stays 0 even in a cycle that pops.
- B has no bypass path. Minimum B latency is 1 cycle (push at cycle N, earliest writeback at N+1).
- Output selection (combinational, 0 cycles from A inputs):
  - If a_valid_i: drive A fields, including wb_ex_valid_o = a_ex_valid_i.
  - Else if count > 0: drive FIFO head with wb_ex_valid_o = 0, and pop.
  - Else: wb_valid_o = 0. Data outputs hold the FIFO head contents (don't-care).
- wb_valid_o is forced to 0 while flush_i is high. No pop happens in that cycle.
- Simultaneous push and pop: count unchanged, pointers both advance; a push into an empty FIFO cannot pop in the same cycle. Pointers wrap modulo DEPTH.
- Flush: on the next edge, FIFO is emptied (pointers and count = 0), starvation counter = 0, stall_a_o = 0. A B handshake presented during flush is dropped.
- Starvation counter (sequential):
  - Increments (saturating at MAX_STALL) in cycles where a_valid_i && count > 0.
  - Clears on any pop or when count == 0.
  - stall_a_o is registered: next = (counter_next >= MAX_STALL). It stays high until a pop occurs or flush.
  - Issue honours stall_a_o from the following cycle. A results already in flight (e.g. multiplier) may still arrive; the counter stays saturated.
- Invariants: at most one writeback per cycle; B order is preserved (FIFO); A is never delayed.

Decomposition:
- Writeback record typedef wb_entry_t {trans_id, result} goes in ariane_pkg, next to the existing fu_data_t.
- TRANS_ID_BITS is reused from ariane_pkg.
- One natural sub-module: wb_fifo, a generic DEPTH-entry circular buffer with push/pop/count/flush. Arbitration and the starvation counter stay in the top.

Test Plan:
1. Reset mid-stream: 3 B entries queued, assert rst_i asynchronously between edges -> immediately fifo_count_o = 0, b_ready_o = 1, stall_a_o = 0, wb_valid_o = 0.
2. B alone: push id 5 / 0xDEAD at cycle 0, A idle -> wb_valid_o = 1 with id 5 / 0xDEAD at cycle 1 only, count 1 then 0.
3. A priority and ordering: B pushes ids 1, 2, 3 while a_valid_i is high 2 cycles with id 7 (ex = 1) -> writebacks in order 7 (ex = 1), 7, 1, 2, 3; B entries have wb_ex_valid_o = 0.
4. Full: DEPTH = 4, 5 B pushes with A continuously valid -> b_ready_o = 0 after 4th accept; 5th held until the cycle after the first pop; no entry lost or duplicated.
5. Starvation: 1 B entry, a_valid_i high for 10 cycles, MAX_STALL = 8 -> stall_a_o rises after 8 starved cycles, stays high while A persists, falls the cycle after the B entry pops.
6. Flush: 2 entries queued plus a B push and flush_i in the same cycle -> wb_valid_o = 0 that cycle; next cycle count = 0, stall_a_o = 0; the pushed entry never appears.

Source files
------------

// File: rtl/ariane_pkg.sv
// Core-wide types: functional-unit dispatch data and writeback records.
// wb_entry_t is the payload carried from a result stream to the scoreboard.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [1:0] {
    FU_NONE,
    FU_ALU,
    FU_MULT,
    FU_VEC
  } fu_t;

  typedef struct packed {
    fu_t                      fu;
    logic [riscv::XLEN-1:0]   operand_a;
    logic [riscv::XLEN-1:0]   operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [riscv::XLEN-1:0]   result;
  } wb_entry_t;
endpackage

// File: rtl/riscv_pkg.sv
// Base RISC-V architectural constants shared by the core.
// Only the integer register width is needed by the writeback path.
package riscv;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/wb_merge_unit_fifo.sv
// Purpose: generic DEPTH-entry circular buffer with push/pop/flush and occupancy count.
// Latency: an entry pushed at edge N is visible at data_o from cycle N+1 (no bypass).
// Backpressure: none internally; the caller gates push on count < DEPTH and pop on count > 0.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_i && !pop_i)      count <= count + CNT_W'(1);
      else if (pop_i && !push_i) count <= count - CNT_W'(1);
    end
  end

  assign data_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/wb_merge_unit.sv
// Purpose: merge fixed-latency A results and FIFO-buffered B results onto one writeback port.
// Latency: A is combinational (0 cycles); B is at least 1 cycle through the FIFO.
// Backpressure: A never stalls; B is held off via b_ready_o; stall_a_o asks issue to yield to B.
module wb_merge_unit
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned XLEN      = riscv::XLEN,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned STALL_W  = $clog2(MAX_STALL + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     a_valid_i,
  input  logic [TRANS_ID_BITS-1:0] a_trans_id_i,
  input  logic [XLEN-1:0]          a_result_i,
  input  logic                     a_ex_valid_i,
  input  logic                     b_valid_i,
  output logic                     b_ready_o,
  input  logic [TRANS_ID_BITS-1:0] b_trans_id_i,
  input  logic [XLEN-1:0]          b_result_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_ex_valid_o,
  output logic                     stall_a_o,
  output logic [CNT_W-1:0]         fifo_count_o
);

  wb_entry_t          push_entry;
  wb_entry_t          head_entry;
  logic               push;
  logic               pop;
  logic               nonempty;
  logic [CNT_W-1:0]   count;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_next;

  assign push_entry.trans_id = b_trans_id_i;
  assign push_entry.result   = b_result_i;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .count_o (count)
  );

  // Ready depends only on the registered count, so a full FIFO stays closed in a popping cycle.
  assign nonempty     = (count != '0);
  assign b_ready_o    = (count < CNT_W'(DEPTH));
  assign push         = b_valid_i && b_ready_o && !flush_i;
  assign fifo_count_o = count;

  // A wins whenever present; the FIFO head drains only in cycles A leaves free.
  always_comb begin
    pop           = 1'b0;
    wb_valid_o    = 1'b0;
    wb_trans_id_o = head_entry.trans_id;
    wb_result_o   = head_entry.result;
    wb_ex_valid_o = 1'b0;
    if (a_valid_i) begin
      wb_valid_o    = !flush_i;
      wb_trans_id_o = a_trans_id_i;
      wb_result_o   = a_result_i;
      wb_ex_valid_o = a_ex_valid_i;
    end else if (nonempty) begin
      wb_valid_o = !flush_i;
      pop        = !flush_i;
    end
  end

  // Count cycles where A blocks a non-empty FIFO; saturate so late in-flight A results keep it high.
  always_comb begin
    stall_cnt_next = stall_cnt;
    if (flush_i || pop || !nonempty) begin
      stall_cnt_next = '0;
    end else if (a_valid_i && (stall_cnt != STALL_W'(MAX_STALL))) begin
      stall_cnt_next = stall_cnt + STALL_W'(1);
    end
  end

  // Registered stall request so issue sees a clean, glitch-free signal.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      stall_a_o <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      stall_a_o <= (stall_cnt_next >= STALL_W'(MAX_STALL));
    end
  end

endmodule

// File: tb/tb_wb_merge_unit.sv
module tb_wb_merge_unit;
  import ariane_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_STALL = 8;
  localparam int unsigned XLEN      = riscv::XLEN;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  logic                     a_valid_i;
  logic [TRANS_ID_BITS-1:0] a_trans_id_i;
  logic [XLEN-1:0]          a_result_i;
  logic                     a_ex_valid_i;
  logic                     b_valid_i;
  logic                     b_ready_o;
  logic [TRANS_ID_BITS-1:0] b_trans_id_i;
  logic [XLEN-1:0]          b_result_i;
  logic                     wb_valid_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [XLEN-1:0]          wb_result_o;
  logic                     wb_ex_valid_o;
  logic                     stall_a_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_o;

  int total = 0;
  int bad   = 0;

  wb_merge_unit #(
    .DEPTH     (DEPTH),
    .MAX_STALL (MAX_STALL),
    .XLEN      (XLEN)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .a_valid_i     (a_valid_i),
    .a_trans_id_i  (a_trans_id_i),
    .a_result_i    (a_result_i),
    .a_ex_valid_i  (a_ex_valid_i),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .b_trans_id_i  (b_trans_id_i),
    .b_result_i    (b_result_i),
    .wb_valid_o    (wb_valid_o),
    .wb_trans_id_o (wb_trans_id_o),
    .wb_result_o   (wb_result_o),
    .wb_ex_valid_o (wb_ex_valid_o),
    .stall_a_o     (stall_a_o),
    .fifo_count_o  (fifo_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        av;
    logic [2:0]  aid;
    logic [63:0] ares;
    logic        aex;
    logic        bv;
    logic [2:0]  bid;
    logic [63:0] bres;
    logic        e_vld;
    logic [2:0]  e_id;
    logic [63:0] e_res;
    logic        e_ex;
    logic        e_rdy;
    int          e_cnt;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic av, logic [2:0] aid, logic [63:0] ares, logic aex,
                              logic bv, logic [2:0] bid, logic [63:0] bres,
                              logic e_vld, logic [2:0] e_id, logic [63:0] e_res, logic e_ex,
                              logic e_rdy, int e_cnt);
    vec_t v;
    v.av = av; v.aid = aid; v.ares = ares; v.aex = aex;
    v.bv = bv; v.bid = bid; v.bres = bres;
    v.e_vld = e_vld; v.e_id = e_id; v.e_res = e_res; v.e_ex = e_ex;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aid, input logic [63:0] ares, input logic aex,
                       input logic bv, input logic [2:0] bid, input logic [63:0] bres, input logic fl);
    a_valid_i = av; a_trans_id_i = aid; a_result_i = ares; a_ex_valid_i = aex;
    b_valid_i = bv; b_trans_id_i = bid; b_result_i = bres; flush_i = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Directed sequence: B alone, A priority with ordering, and the FIFO-full case.
    vecs[0]  = mk(0, 0, 0,     0, 1, 5, 64'hDEAD, 0, 0, 0,        0, 1, 0);
    vecs[1]  = mk(0, 0, 0,     0, 0, 0, 0,        1, 5, 64'hDEAD, 0, 1, 1);
    vecs[2]  = mk(0, 0, 0,     0, 0, 0, 0,        0, 0, 0,        0, 1, 0);
    vecs[3]  = mk(1, 7, 'h70,  1, 1, 1, 'h11,     1, 7, 'h70,     1, 1, 0);
    vecs[4]  = mk(1, 7, 'h71,  0, 1, 2, 'h22,     1, 7, 'h71,     0, 1, 1);
    vecs[5]  = mk(0, 0, 0,     0, 1, 3, 'h33,     1, 1, 'h11,     0, 1, 2);
    vecs[6]  = mk(0, 0, 0,     0, 0, 0, 0,        1, 2, 'h22,     0, 1, 2);
    vecs[7]  = mk(0, 0, 0,     0, 0, 0, 0,        1, 3, 'h33,     0, 1, 1);
    vecs[8]  = mk(0, 0, 0,     0, 0, 0, 0,        0, 0, 0,        0, 1, 0);
    vecs[9]  = mk(1, 6, 'hA0,  0, 1, 1, 'h101,    1, 6, 'hA0,     0, 1, 0);
    vecs[10] = mk(1, 6, 'hA0,  0, 1, 2, 'h102,    1, 6, 'hA0,     0, 1, 1);
    vecs[11] = mk(1, 6, 'hA0,  0, 1, 3, 'h103,    1, 6, 'hA0,     0, 1, 2);
    vecs[12] = mk(1, 6, 'hA0,  0, 1, 4, 'h104,    1, 6, 'hA0,     0, 1, 3);
    vecs[13] = mk(1, 6, 'hA0,  0, 1, 5, 'h105,    1, 6, 'hA0,     0, 0, 4);
    vecs[14] = mk(0, 0, 0,     0, 1, 5, 'h105,    1, 1, 'h101,    0, 0, 4);
    vecs[15] = mk(0, 0, 0,     0, 1, 5, 'h105,    1, 2, 'h102,    0, 1, 3);
    vecs[16] = mk(0, 0, 0,     0, 0, 0, 0,        1, 3, 'h103,    0, 1, 3);
    vecs[17] = mk(0, 0, 0,     0, 0, 0, 0,        1, 4, 'h104,    0, 1, 2);
    vecs[18] = mk(0, 0, 0,     0, 0, 0, 0,        1, 5, 'h105,    0, 1, 1);
    vecs[19] = mk(0, 0, 0,     0, 0, 0, 0,        0, 0, 0,        0, 1, 0);

    rst_i = 1'b1;
    idle();
    #2;
    chk("reset_cnt",   64'(fifo_count_o), 0);
    chk("reset_rdy",   64'(b_ready_o), 1);
    chk("reset_vld",   64'(wb_valid_o), 0);
    chk("reset_stall", 64'(stall_a_o), 0);
    #10 rst_i = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].av, vecs[i].aid, vecs[i].ares, vecs[i].aex,
            vecs[i].bv, vecs[i].bid, vecs[i].bres, 0);
      #4;
      chk($sformatf("vec%0d_vld", i), 64'(wb_valid_o), 64'(vecs[i].e_vld));
      chk($sformatf("vec%0d_rdy", i), 64'(b_ready_o), 64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_cnt", i), 64'(fifo_count_o), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_stall", i), 64'(stall_a_o), 0);
      if (vecs[i].e_vld) begin
        chk($sformatf("vec%0d_id", i), 64'(wb_trans_id_o), 64'(vecs[i].e_id));
        chk($sformatf("vec%0d_res", i), 64'(wb_result_o), vecs[i].e_res);
        chk($sformatf("vec%0d_ex", i), 64'(wb_ex_valid_o), 64'(vecs[i].e_ex));
      end
      step();
    end

    // Starvation: one queued B entry held off by ten cycles of A.
    drive(0, 0, 0, 0, 1, 4, 'h44, 0);
    #4 chk("starve_push_vld", 64'(wb_valid_o), 0);
    step();
    for (int k = 1; k <= 10; k++) begin
      drive(1, 1, 'h1A, 0, 0, 0, 0, 0);
      #4;
      chk($sformatf("starve%0d_stall", k), 64'(stall_a_o), (k >= 9) ? 64'd1 : 64'd0);
      chk($sformatf("starve%0d_cnt", k), 64'(fifo_count_o), 1);
      chk($sformatf("starve%0d_id", k), 64'(wb_trans_id_o), 1);
      step();
    end
    idle();
    #4;
    chk("starve_pop_vld", 64'(wb_valid_o), 1);
    chk("starve_pop_id", 64'(wb_trans_id_o), 4);
    chk("starve_pop_res", wb_result_o, 'h44);
    chk("starve_pop_ex", 64'(wb_ex_valid_o), 0);
    chk("starve_pop_stall", 64'(stall_a_o), 1);
    step();
    #4;
    chk("starve_after_stall", 64'(stall_a_o), 0);
    chk("starve_after_cnt", 64'(fifo_count_o), 0);
    chk("starve_after_vld", 64'(wb_valid_o), 0);
    step();

    // Flush with two queued entries, a raised stall and a simultaneous B handshake.
    for (int f = 0; f < 10; f++) begin
      if (f < 2) drive(1, 3, 'h3C, 0, 1, 3'(f + 1), 64'('h201 + f), 0);
      else       drive(1, 3, 'h3C, 0, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 5, 'h205, 1);
    #4;
    chk("flush_vld", 64'(wb_valid_o), 0);
    chk("flush_cnt", 64'(fifo_count_o), 2);
    chk("flush_stall_pre", 64'(stall_a_o), 1);
    step();
    idle();
    #4;
    chk("flush_next_cnt", 64'(fifo_count_o), 0);
    chk("flush_next_stall", 64'(stall_a_o), 0);
    chk("flush_next_vld", 64'(wb_valid_o), 0);
    chk("flush_next_rdy", 64'(b_ready_o), 1);
    step();
    #4 chk("flush_drop_vld", 64'(wb_valid_o), 0);
    step();

    // Asynchronous reset between edges with three B entries queued.
    for (int r = 0; r < 3; r++) begin
      drive(1, 2, 'h55, 0, 1, 3'(r + 1), 64'('h301 + r), 0);
      step();
    end
    idle();
    #1;
    chk("rst_pre_cnt", 64'(fifo_count_o), 3);
    chk("rst_pre_vld", 64'(wb_valid_o), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_async_cnt", 64'(fifo_count_o), 0);
    chk("rst_async_rdy", 64'(b_ready_o), 1);
    chk("rst_async_stall", 64'(stall_a_o), 0);
    chk("rst_async_vld", 64'(wb_valid_o), 0);
    #3 rst_i = 1'b0;
    step();
    #4;
    chk("rst_after_vld", 64'(wb_valid_o), 0);
    chk("rst_after_cnt", 64'(fifo_count_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
